seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of scanned positions captured per frame (1..8).
REQ-002 Parameter STABLE_CYCLES, default 16: clk cycles that {cs, dig_sel} must hold unchanged before a sample is accepted (2..255).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cs  input  8  digit select from the display driver; active-low, one-hot; bit i selects position i.
REQ-006 dig_sel  input  8  segment bus, active-low, bit order {dp,g,f,e,d,c,b,a}.
REQ-007 digits  output  4*NUM_DIGITS  decoded hex value per position; position i at [4i+3:4i].
REQ-008 dots  output  NUM_DIGITS  decimal point per position; 1 = lit.
REQ-009 blank  output  NUM_DIGITS  1 = position was all segments off.
REQ-010 frame_valid  output  1  one-cycle pulse when digits/dots/blank update.
REQ-011 pattern_err  output  1  one-cycle pulse on an undecodable segment pattern.
REQ-012 cs_err  output  1  one-cycle pulse when cs has more than one low bit.

Function
REQ-013 cs and dig_sel SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 A stability counter SHALL clear to 0 in any cycle where synchronized {cs,dig_sel} differs from the previous cycle; otherwise it increments, saturating at STABLE_CYCLES.
REQ-015 A sample SHALL be taken exactly once per stable period, in the cycle the counter first reaches STABLE_CYCLES-1.
REQ-016 Sample with cs all-ones: ignored, no error.
REQ-017 Sample with more than one cs bit low: cs_err pulses the next cycle; nothing captured.
REQ-018 Sample with single low bit at index >= NUM_DIGITS: ignored, no error.
REQ-019 Decode on dig_sel[6:0]: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex).
REQ-020 dig_sel[6:0]=7F: blank=1, digit=0; any other unlisted pattern: pattern_err pulses next cycle and nothing captured for that position.
REQ-021 dot = ~dig_sel[7] for every captured (including blank) position.
REQ-022 A valid capture SHALL write shadow registers for its position and set that position's bit in a seen mask; re-capturing a position before frame completion overwrites the shadow without other effect.
REQ-023 When the seen mask becomes all-ones, the cycle after the completing capture: shadow copied to digits/dots/blank, frame_valid pulses, seen mask clears to 0.
REQ-024 Outputs digits/dots/blank SHALL hold between frames; total latency from input change to frame_valid = 2 (sync) + STABLE_CYCLES + 1 cycles after the last position's change.
REQ-025 pattern_err and cs_err SHALL never pulse in the same cycle as each other; frame_valid MAY coincide with neither (error samples never complete a frame).

Reset
REQ-026 On rst_n low: digits=0, dots=0, blank=all-ones, frame_valid=0, pattern_err=0, cs_err=0, seen mask=0, stability counter=0, synchronizers=all-ones, asynchronously.
REQ-027 Reset asserted mid-frame SHALL discard partial captures; first frame_valid after release requires all NUM_DIGITS positions recaptured.

Verification
V-1 NUM_DIGITS=4, scan cs FE/FD/FB/F7 with dig_sel B0/92/C0/F9, 40 cycles each -> one frame_valid, digits=16'h1053 (pos0=3), dots=0, blank=0.
V-2 Same scan with dig_sel=10 (dot lit) on pos2 -> digits[11:8]=9, dots=4'b0100.
V-3 pos1 holds dig_sel=FF -> blank=4'b0010, digits[7:4]=0, frame_valid still pulses.
V-4 cs=FC held 40 cycles -> single cs_err pulse, no frame; dig_sel=AA on a valid position -> single pattern_err, frame withheld until a legal pattern for that position.
V-5 Toggle dig_sel every 8 cycles with STABLE_CYCLES=16 -> no capture, no pulses; then hold -> capture exactly once.
V-6 Assert rst_n after positions 0-2 captured, release, scan only position 3 -> no frame_valid; outputs at reset values.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Snoops a multiplexed 7-segment display bus and reconstructs the shown digits.
// Only a value that has been held steadily long enough is captured; a frame is published once every position has been seen.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              cs,
    input  logic [7:0]              dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dots,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic                    cs_err
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] SAMPLE_AT  = 8'(STABLE_CYCLES - 1);

    logic [7:0] cs_meta_reg, cs_sync_reg, seg_meta_reg, seg_sync_reg;
    logic [7:0] cs_prev_reg, seg_prev_reg;
    logic [7:0] stable_cnt_reg;
    logic [NUM_DIGITS-1:0]   seen_reg, seen_next;
    logic [4*NUM_DIGITS-1:0] shd_digits_reg, shd_digits_next;
    logic [NUM_DIGITS-1:0]   shd_dots_reg, shd_dots_next;
    logic [NUM_DIGITS-1:0]   shd_blank_reg, shd_blank_next;
    logic [NUM_DIGITS-1:0]   pos_hit;

    logic       changed, sample, multi_low, single_low, in_range;
    logic       capture, pat_bad, frame_done;
    logic [7:0] inv_cs;
    logic [2:0] sel_idx;
    logic [5:0] dec;

    // Returns {legal, blank, hex value}; the bus is active-low so lit segments read as 0.
    function automatic logic [5:0] decode_seg(input logic [6:0] p);
        case (p)
            7'h40:   decode_seg = {2'b10, 4'h0};
            7'h79:   decode_seg = {2'b10, 4'h1};
            7'h24:   decode_seg = {2'b10, 4'h2};
            7'h30:   decode_seg = {2'b10, 4'h3};
            7'h19:   decode_seg = {2'b10, 4'h4};
            7'h12:   decode_seg = {2'b10, 4'h5};
            7'h02:   decode_seg = {2'b10, 4'h6};
            7'h78:   decode_seg = {2'b10, 4'h7};
            7'h00:   decode_seg = {2'b10, 4'h8};
            7'h10:   decode_seg = {2'b10, 4'h9};
            7'h08:   decode_seg = {2'b10, 4'hA};
            7'h03:   decode_seg = {2'b10, 4'hB};
            7'h46:   decode_seg = {2'b10, 4'hC};
            7'h21:   decode_seg = {2'b10, 4'hD};
            7'h06:   decode_seg = {2'b10, 4'hE};
            7'h0E:   decode_seg = {2'b10, 4'hF};
            7'h7F:   decode_seg = {2'b11, 4'h0};
            default: decode_seg = 6'b00_0000;
        endcase
    endfunction

    // The stable value lives in the *_prev registers, so the sample is unaffected by a change arriving that same cycle.
    always_comb begin
        changed    = {cs_sync_reg, seg_sync_reg} != {cs_prev_reg, seg_prev_reg};
        sample     = stable_cnt_reg == SAMPLE_AT;
        inv_cs     = ~cs_prev_reg;
        multi_low  = |(inv_cs & (inv_cs - 8'd1));
        single_low = (inv_cs != 8'd0) && !multi_low;
        sel_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (inv_cs[i]) sel_idx = 3'(i);
        end
        in_range   = single_low && ({1'b0, sel_idx} < 4'(NUM_DIGITS));
        dec        = decode_seg(seg_prev_reg[6:0]);
        capture    = sample && in_range && dec[5];
        pat_bad    = sample && in_range && !dec[5];
        seen_next  = seen_reg | pos_hit;
        frame_done = capture && (&seen_next);
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            assign pos_hit[gi] = capture && (sel_idx == 3'(gi));
            assign shd_digits_next[4*gi +: 4] = pos_hit[gi] ? dec[3:0] : shd_digits_reg[4*gi +: 4];
            assign shd_dots_next[gi]  = pos_hit[gi] ? ~seg_prev_reg[7] : shd_dots_reg[gi];
            assign shd_blank_next[gi] = pos_hit[gi] ? dec[4] : shd_blank_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_reg    <= 8'hFF;
            cs_sync_reg    <= 8'hFF;
            seg_meta_reg   <= 8'hFF;
            seg_sync_reg   <= 8'hFF;
            cs_prev_reg    <= 8'hFF;
            seg_prev_reg   <= 8'hFF;
            stable_cnt_reg <= 8'd0;
            seen_reg       <= '0;
            shd_digits_reg <= '0;
            shd_dots_reg   <= '0;
            shd_blank_reg  <= '1;
            digits         <= '0;
            dots           <= '0;
            blank          <= '1;
            frame_valid    <= 1'b0;
            pattern_err    <= 1'b0;
            cs_err         <= 1'b0;
        end else begin
            cs_meta_reg  <= cs;
            cs_sync_reg  <= cs_meta_reg;
            seg_meta_reg <= dig_sel;
            seg_sync_reg <= seg_meta_reg;
            cs_prev_reg  <= cs_sync_reg;
            seg_prev_reg <= seg_sync_reg;
            if (changed)
                stable_cnt_reg <= 8'd0;
            else if (stable_cnt_reg != STABLE_MAX)
                stable_cnt_reg <= stable_cnt_reg + 8'd1;
            shd_digits_reg <= shd_digits_next;
            shd_dots_reg   <= shd_dots_next;
            shd_blank_reg  <= shd_blank_next;
            cs_err         <= sample && multi_low;
            pattern_err    <= pat_bad;
            frame_valid    <= frame_done;
            if (frame_done) begin
                digits   <= shd_digits_next;
                dots     <= shd_dots_next;
                blank    <= shd_blank_next;
                seen_reg <= '0;
            end else begin
                seen_reg <= seen_next;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomised and directed checks of seg_scan_capture against a per-position display model.
module tb_seg_scan_capture;
    localparam int ND = 4;
    localparam int SC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] cs = 8'hFF;
    logic [7:0] dig_sel = 8'hFF;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] dots, blank;
    logic frame_valid, pattern_err, cs_err;

    seg_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .dig_sel(dig_sel),
        .digits(digits), .dots(dots), .blank(blank),
        .frame_valid(frame_valid), .pattern_err(pattern_err), .cs_err(cs_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int fv_cnt, ce_cnt, pe_cnt, both_cnt, fv_cyc, last_drive;
    int n_cmp = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (frame_valid) begin fv_cnt++; fv_cyc = cyc; end
        if (cs_err) ce_cnt++;
        if (pattern_err) pe_cnt++;
        if (cs_err && pattern_err) both_cnt++;
    end

    // Standard segment codes (active-low, {g..a}) for hex 0..F.
    logic [6:0] seg_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int       m_val [ND];
    bit       m_dot [ND];
    bit       m_blank [ND];

    function automatic logic [7:0] pat(input int v, input bit dot, input bit blk);
        logic [6:0] s;
        s = blk ? 7'h7F : seg_code[v];
        return {~dot, s};
    endfunction

    function automatic logic [7:0] cs_of(input int p);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << p);
    endfunction

    task automatic clear_counts();
        fv_cnt = 0; ce_cnt = 0; pe_cnt = 0; both_cnt = 0; fv_cyc = 0;
    endtask

    task automatic drive(input logic [7:0] c, input logic [7:0] d, input int n);
        @(posedge clk);
        #1;
        cs = c;
        dig_sel = d;
        last_drive = cyc;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (digits !== 16'h0) begin n_err++; $display("FAIL reset_digits: got %h want 0000", digits); end
        n_cmp++; if (dots !== 4'h0) begin n_err++; $display("FAIL reset_dots: got %b want 0000", dots); end
        n_cmp++; if (blank !== 4'hF) begin n_err++; $display("FAIL reset_blank: got %b want 1111", blank); end
        n_cmp++; if ({frame_valid, pattern_err, cs_err} !== 3'b000) begin
            n_err++; $display("FAIL reset_pulses: got %b want 000", {frame_valid, pattern_err, cs_err}); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_basic();
        clear_counts();
        drive(8'hFF, 8'hFF, 20);
        drive(8'hFE, 8'hB0, 40);
        drive(8'hFD, 8'h92, 40);
        drive(8'hFB, 8'hC0, 40);
        drive(8'hF7, 8'hF9, 40);
        @(negedge clk);
        n_cmp++; if (fv_cnt !== 1) begin n_err++; $display("FAIL basic_frames: got %0d want 1", fv_cnt); end
        n_cmp++; if (digits !== 16'h1053) begin n_err++; $display("FAIL basic_digits: got %h want 1053", digits); end
        n_cmp++; if (dots !== 4'h0 || blank !== 4'h0) begin
            n_err++; $display("FAIL basic_dots_blank: got %b/%b want 0000/0000", dots, blank); end
        n_cmp++; if (fv_cyc - last_drive !== SC + 3) begin
            n_err++; $display("FAIL basic_latency: got %0d want %0d", fv_cyc - last_drive, SC + 3); end
    endtask

    task automatic test_dot_blank();
        clear_counts();
        drive(8'hFF, 8'hFF, 20);
        drive(8'hFE, 8'hB0, 40);
        drive(8'hFD, 8'hFF, 40);
        drive(8'hFB, 8'h10, 40);
        drive(8'hF7, 8'hF9, 40);
        @(negedge clk);
        n_cmp++; if (fv_cnt !== 1) begin n_err++; $display("FAIL dotblank_frames: got %0d want 1", fv_cnt); end
        n_cmp++; if (digits !== 16'h1903) begin n_err++; $display("FAIL dotblank_digits: got %h want 1903", digits); end
        n_cmp++; if (dots !== 4'b0100) begin n_err++; $display("FAIL dotblank_dots: got %b want 0100", dots); end
        n_cmp++; if (blank !== 4'b0010) begin n_err++; $display("FAIL dotblank_blank: got %b want 0010", blank); end
    endtask

    task automatic test_errors();
        clear_counts();
        drive(8'hFF, 8'hFF, 20);
        drive(8'hFC, 8'hB0, 40);
        n_cmp++; if (ce_cnt !== 1) begin n_err++; $display("FAIL err_cs_pulse: got %0d want 1", ce_cnt); end
        drive(8'hEF, 8'hB0, 40);
        n_cmp++; if (ce_cnt !== 1 || pe_cnt !== 0) begin
            n_err++; $display("FAIL err_out_of_range: got cs_err %0d pat_err %0d want 1 0", ce_cnt, pe_cnt); end
        drive(8'hFE, 8'hB0, 40);
        drive(8'hFD, 8'hAA, 40);
        drive(8'hFB, 8'hC0, 40);
        drive(8'hF7, 8'hF9, 40);
        @(negedge clk);
        n_cmp++; if (pe_cnt !== 1) begin n_err++; $display("FAIL err_pattern_pulse: got %0d want 1", pe_cnt); end
        n_cmp++; if (fv_cnt !== 0) begin n_err++; $display("FAIL err_frame_withheld: got %0d want 0", fv_cnt); end
        n_cmp++; if (digits !== 16'h1903) begin n_err++; $display("FAIL err_hold_digits: got %h want 1903", digits); end
        drive(8'hFD, 8'h92, 40);
        @(negedge clk);
        n_cmp++; if (fv_cnt !== 1 || digits !== 16'h1053) begin
            n_err++; $display("FAIL err_recover: got %0d frames digits %h want 1 1053", fv_cnt, digits); end
        n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL err_coincident: got %0d want 0", both_cnt); end
    endtask

    task automatic test_unstable();
        clear_counts();
        drive(8'hFF, 8'hFF, 20);
        drive(8'hFD, 8'h92, 40);
        drive(8'hFB, 8'hC0, 40);
        drive(8'hF7, 8'hF9, 40);
        for (int k = 0; k < 8; k++) drive(8'hFE, (k % 2 == 0) ? 8'hB0 : 8'h92, 8);
        n_cmp++; if (fv_cnt + pe_cnt + ce_cnt !== 0) begin
            n_err++; $display("FAIL unstable_quiet: got %0d pulses want 0", fv_cnt + pe_cnt + ce_cnt); end
        drive(8'hFE, 8'h99, 80);
        @(negedge clk);
        n_cmp++; if (fv_cnt !== 1) begin n_err++; $display("FAIL unstable_once: got %0d want 1", fv_cnt); end
        n_cmp++; if (digits !== 16'h1054) begin n_err++; $display("FAIL unstable_digits: got %h want 1054", digits); end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        drive(8'hFF, 8'hFF, 20);
        drive(8'hFE, 8'hB0, 40);
        drive(8'hFD, 8'h92, 40);
        drive(8'hFB, 8'hC0, 40);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (digits !== 16'h0 || blank !== 4'hF) begin
            n_err++; $display("FAIL midreset_async: got %h/%b want 0000/1111", digits, blank); end
        @(negedge clk) rst_n = 1'b1;
        drive(8'hF7, 8'hF9, 60);
        @(negedge clk);
        n_cmp++; if (fv_cnt !== 0) begin n_err++; $display("FAIL midreset_no_frame: got %0d want 0", fv_cnt); end
        n_cmp++; if (digits !== 16'h0 || dots !== 4'h0 || blank !== 4'hF) begin
            n_err++; $display("FAIL midreset_outputs: got %h/%b/%b want 0000/0000/1111", digits, dots, blank); end
    endtask

    task automatic test_random(input int frames);
        int order [ND];
        int p, t, j;
        logic [4*ND-1:0] exp_digits;
        logic [ND-1:0] exp_dots, exp_blank;
        for (int f = 0; f < frames; f++) begin
            clear_counts();
            for (int i = 0; i < ND; i++) order[i] = i;
            for (int i = ND - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
            drive(8'hFF, 8'hFF, 20);
            for (int i = 0; i < ND; i++) begin
                if (i == ND - 1 && $urandom_range(1, 0) == 1) begin
                    p = order[$urandom_range(ND - 2, 0)];
                    m_val[p] = $urandom_range(15, 0); m_dot[p] = 1'($urandom_range(1, 0));
                    m_blank[p] = ($urandom_range(5, 0) == 0);
                    drive(cs_of(p), pat(m_val[p], m_dot[p], m_blank[p]), $urandom_range(40, 20));
                end
                if ($urandom_range(3, 0) == 0)
                    drive(cs_of($urandom_range(7, ND)), 8'($urandom), $urandom_range(40, 20));
                p = order[i];
                m_val[p] = $urandom_range(15, 0); m_dot[p] = 1'($urandom_range(1, 0));
                m_blank[p] = ($urandom_range(5, 0) == 0);
                drive(cs_of(p), pat(m_val[p], m_dot[p], m_blank[p]), $urandom_range(40, 20));
            end
            repeat (5) @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                exp_digits[4*i +: 4] = m_blank[i] ? 4'h0 : 4'(m_val[i]);
                exp_dots[i] = m_dot[i];
                exp_blank[i] = m_blank[i];
            end
            n_cmp++; if (fv_cnt !== 1) begin n_err++; $display("FAIL rand_frames[%0d]: got %0d want 1", f, fv_cnt); end
            n_cmp++; if (digits !== exp_digits) begin
                n_err++; $display("FAIL rand_digits[%0d]: got %h want %h", f, digits, exp_digits); end
            n_cmp++; if (dots !== exp_dots || blank !== exp_blank) begin
                n_err++; $display("FAIL rand_dots_blank[%0d]: got %b/%b want %b/%b", f, dots, blank, exp_dots, exp_blank); end
            n_cmp++; if (fv_cyc - last_drive !== SC + 3) begin
                n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", f, fv_cyc - last_drive, SC + 3); end
            n_cmp++; if (pe_cnt + ce_cnt !== 0) begin
                n_err++; $display("FAIL rand_errors[%0d]: got %0d want 0", f, pe_cnt + ce_cnt); end
            $display("frame %0d: digits=%h dots=%b blank=%b", f, digits, dots, blank);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dot_blank();
        test_errors();
        test_unstable();
        test_reset_midframe();
        test_random(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
